// File: rtl/video_timing_gen.sv
// Raster timing generator: signed hpos/vpos with blanking at negative coordinates,
// plus registered hsync/vsync/de/vblank/fsync decoded from the next-state counters.
module video_timing_gen #(
    parameter int HRES   = 1280,
    parameter int H_FP   = 110,
    parameter int H_SYNC = 40,
    parameter int H_BP   = 220,
    parameter int VRES   = 720,
    parameter int V_FP   = 5,
    parameter int V_SYNC = 5,
    parameter int V_BP   = 20,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               fsync,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               vblank
);

    localparam logic signed [11:0] HMIN   = 12'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [11:0] HLAST  = 12'(HRES - 1);
    localparam logic signed [11:0] HS_BEG = 12'(-(H_SYNC + H_BP));
    localparam logic signed [11:0] HS_END = 12'(-H_BP - 1);
    localparam logic signed [11:0] VMIN   = 12'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [11:0] VLAST  = 12'(VRES - 1);
    localparam logic signed [11:0] VS_BEG = 12'(-(V_SYNC + V_BP));
    localparam logic signed [11:0] VS_END = 12'(-V_BP - 1);

    logic signed [11:0] h_nxt;
    logic signed [11:0] v_nxt;
    logic               h_wrap;
    logic               f_wrap;

    always_comb begin
        h_wrap = (hpos == HLAST);
        f_wrap = h_wrap && (vpos == VLAST);
        h_nxt  = h_wrap ? HMIN : hpos + 12'sd1;
        v_nxt  = vpos;
        if (h_wrap) begin
            v_nxt = (vpos == VLAST) ? VMIN : vpos + 12'sd1;
        end
    end

    // Flags decode h_nxt/v_nxt so they line up with the counter they describe.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos   <= HMIN;
            vpos   <= VMIN;
            fsync  <= 1'b0;
            hsync  <= ~HS_POL;
            vsync  <= ~VS_POL;
            de     <= 1'b0;
            vblank <= 1'b1;
        end else begin
            hpos   <= h_nxt;
            vpos   <= v_nxt;
            fsync  <= f_wrap;
            hsync  <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HS_POL : ~HS_POL;
            vsync  <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VS_POL : ~VS_POL;
            de     <= ~h_nxt[11] & ~v_nxt[11];
            vblank <= v_nxt[11];
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 720p instance for reset/line timing, and a
// reduced-size instance for whole-frame, fsync and mid-frame reset behaviour.
module tb_video_timing_gen;

    localparam int S_HRES = 16, S_HFP = 3, S_HSYNC = 4, S_HBP = 5;
    localparam int S_VRES = 8, S_VFP = 2, S_VSYNC = 2, S_VBP = 3;
    localparam int S_LINE = 28, S_FRAME = 420;
    localparam int D_LINE = 1650;

    if (S_HRES - 1 > 2047 || S_VRES - 1 > 2047 ||
        -(S_HFP + S_HSYNC + S_HBP) < -2048 ||
        -(S_VFP + S_VSYNC + S_VBP) < -2048 ||
        1280 - 1 > 2047 || -(110 + 40 + 220) < -2048) begin : g_bad_cfg
        $error("timing parameters exceed 12-bit signed counter range");
    end

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic signed [11:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic d_fsync, d_hsync, d_vsync, d_de, d_vblank;
    logic s_fsync, s_hsync, s_vsync, s_de, s_vblank;

    video_timing_gen u_def (
        .pixel_clk(clk), .rst_n(rst_n),
        .hpos(d_hpos), .vpos(d_vpos), .fsync(d_fsync),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .vblank(d_vblank)
    );

    video_timing_gen #(
        .HRES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
        .VRES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_sml (
        .pixel_clk(clk), .rst_n(rst_n),
        .hpos(s_hpos), .vpos(s_vpos), .fsync(s_fsync),
        .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .vblank(s_vblank)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int d_pos_bad = 0, d_hs_bad = 0, d_blank_bad = 0, d_hs_cnt = 0;
    int d_wrap_ok = 0;
    int s_pos_bad = 0, s_hs_bad = 0, s_vs_bad = 0, s_de_bad = 0;
    int s_vb_bad = 0, s_fs_bad = 0, s_de_cnt = 0, s_vs_edge_bad = 0;
    int s_vs_edges = 0, f1 = 0, f2 = 0;
    int first_dh = 99, first_dv = 99, last_dh = 99, last_dv = 99;
    logic prev_vs;
    logic signed [11:0] prev_dh;

    initial begin
        int off, dh, dv, sh, sv, k;
        bit found, hs_e, vs_e;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d_hpos", d_hpos, -370);
        chk("rst_d_vpos", d_vpos, -30);
        chk("rst_d_de", d_de, 0);
        chk("rst_d_fsync", d_fsync, 0);
        chk("rst_d_hsync", d_hsync, 0);
        chk("rst_d_vsync", d_vsync, 0);
        chk("rst_d_vblank", d_vblank, 1);
        chk("rst_s_hpos", s_hpos, -12);
        chk("rst_s_vpos", s_vpos, -7);

        rst_n = 1'b1;
        prev_vs = s_vsync;
        prev_dh = d_hpos;
        for (int n = 1; n <= 1700; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("first_edge_d_hpos", d_hpos, -369);
                chk("first_edge_s_hpos", s_hpos, -11);
            end
            off = n % (D_LINE * 750);
            dh = -370 + off % D_LINE;
            dv = -30 + off / D_LINE;
            if (d_hpos !== 12'(dh) || d_vpos !== 12'(dv)) d_pos_bad++;
            hs_e = (dh >= -260 && dh <= -221);
            if (d_hsync !== hs_e) d_hs_bad++;
            if (n <= D_LINE && d_hsync === 1'b1) d_hs_cnt++;
            if (d_de !== 1'b0 || d_vblank !== 1'b1 || d_fsync !== 1'b0)
                d_blank_bad++;
            if (prev_dh == 12'sd1279 && d_hpos == -12'sd370 &&
                d_vpos == -12'sd29) d_wrap_ok++;
            prev_dh = d_hpos;

            off = n % S_FRAME;
            sh = -12 + off % S_LINE;
            sv = -7 + off / S_LINE;
            if (s_hpos !== 12'(sh) || s_vpos !== 12'(sv)) s_pos_bad++;
            if (s_hsync !== (sh >= -9 && sh <= -6)) s_hs_bad++;
            vs_e = (sv >= -5 && sv <= -4);
            if (s_vsync !== vs_e) s_vs_bad++;
            if (s_de !== (sh >= 0 && sv >= 0)) s_de_bad++;
            if (s_vblank !== (sv < 0)) s_vb_bad++;
            if (s_fsync !== (off == 0)) s_fs_bad++;
            if (s_vsync !== prev_vs) begin
                if (n <= S_FRAME) s_vs_edges++;
                if (s_hpos !== -12'sd12) s_vs_edge_bad++;
            end
            prev_vs = s_vsync;
            if (s_fsync === 1'b1) begin
                if (f1 == 0) f1 = n;
                else if (f2 == 0) f2 = n;
            end
            if (n <= S_FRAME && s_de === 1'b1) begin
                s_de_cnt++;
                if (first_dh == 99) begin
                    first_dh = s_hpos;
                    first_dv = s_vpos;
                end
                last_dh = s_hpos;
                last_dv = s_vpos;
            end
        end

        chk("d_position_track", d_pos_bad, 0);
        chk("d_hsync_window", d_hs_bad, 0);
        chk("d_hsync_width", d_hs_cnt, 40);
        chk("d_blanking_flags", d_blank_bad, 0);
        chk("d_line_wrap", d_wrap_ok, 1);
        chk("s_position_track", s_pos_bad, 0);
        chk("s_hsync_window", s_hs_bad, 0);
        chk("s_vsync_window", s_vs_bad, 0);
        chk("s_de_window", s_de_bad, 0);
        chk("s_vblank", s_vb_bad, 0);
        chk("s_fsync_pattern", s_fs_bad, 0);
        chk("s_first_fsync", f1, S_FRAME);
        chk("s_second_fsync", f2, 2 * S_FRAME);
        chk("s_de_count", s_de_cnt, 128);
        chk("s_first_de_h", first_dh, 0);
        chk("s_first_de_v", first_dv, 0);
        chk("s_last_de_h", last_dh, 15);
        chk("s_last_de_v", last_dv, 7);
        chk("s_vsync_edges", s_vs_edges, 2);
        chk("s_vsync_edge_at_hmin", s_vs_edge_bad, 0);

        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (s_hpos == 12'sd5 && s_vpos == 12'sd3) found = 1'b1;
        end
        chk("midframe_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_s_hpos", s_hpos, -12);
        chk("async_s_vpos", s_vpos, -7);
        chk("async_s_de", s_de, 0);
        chk("async_s_fsync", s_fsync, 0);
        chk("async_s_hsync", s_hsync, 0);
        chk("async_s_vsync", s_vsync, 0);
        chk("async_s_vblank", s_vblank, 1);
        chk("async_d_hpos", d_hpos, -370);
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_fsync !== 1'b0 || s_hpos !== -12'sd12) k++;
        end
        chk("reset_hold_stable", k, 0);

        rst_n = 1'b1;
        found = 1'b0;
        k = 0;
        for (int i = 1; i <= 1000 && !found; i++) begin
            @(negedge clk);
            if (s_fsync === 1'b1) begin
                found = 1'b1;
                k = i;
            end
        end
        chk("restart_fsync_found", found, 1);
        chk("restart_fsync_delay", k, S_FRAME);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator that drives the hpos/vpos/fsync interface consumed by the on-screen object and paddle blocks. It also produces hsync, vsync and de for the HDMI/DVI encoder. It defaults to CEA-861 1280x720p60. Counters are signed so that blanking maps to negative coordinates and the active area maps to 0..HRES-1 and 0..VRES-1.

Parameters:
HRES, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync width (pixels)
H_BP, 220, horizontal back porch (pixels)
VRES, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
hpos  out  12 signed  current pixel x; range HMIN..HRES-1
vpos  out  12 signed  current pixel y; range VMIN..VRES-1
fsync  out  1  one-cycle frame-start pulse
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
de  out  1  data enable, high in the active area
vblank  out  1  high while vpos < 0

Behaviour:
- Derived constants:
  - HMIN = -(H_FP+H_SYNC+H_BP), default -370.
  - VMIN = -(V_FP+V_SYNC+V_BP), default -30.
  - Line total 1650 clocks. Frame total 750 lines.
- Width constraints:
  - HRES-1 <= 2047, VRES-1 <= 2047.
  - HMIN >= -2048, VMIN >= -2048.
  - The default parameter set satisfies these. The bench checks them with an elaboration-time assertion.
- Reset (rst_n low, asynchronous; effective immediately regardless of clock):
  - hpos=HMIN, vpos=VMIN.
  - fsync=0, de=0, vblank=1.
  - hsync=!HS_POL, vsync=!VS_POL.
  - Reset may be asserted mid-line or mid-frame. Outputs return to reset values at once, with no partial pulses held.
- Deassertion: counting starts on the first rising edge at which rst_n is high. Synchronising rst_n deassertion is the integrator's job.
- Horizontal counter:
  - Increments by 1 every clock.
  - At HRES-1 it wraps to HMIN on the next clock and the vertical counter advances.
- Vertical counter:
  - Increments only when hpos wraps.
  - At VRES-1 (with hpos wrapping) it wraps to VMIN.
- Line order in hpos: FP [HMIN, HMIN+H_FP-1] → sync [HMIN+H_FP, HMIN+H_FP+H_SYNC-1] → BP [-H_BP, -1] → active [0, HRES-1].
  - Defaults: FP -370..-261, sync -260..-221, BP -220..-1.
  - vpos uses the same order with the V_ parameters. Default vsync lines are -25..-21.
- All outputs are registered and cycle-consistent: in any cycle, hsync, vsync, de, vblank and fsync describe the hpos/vpos values presented in that same cycle. Implement this by decoding from next-state counter values, not by delaying the counters.
- de = (hpos >= 0) && (vpos >= 0).
- vsync is a level over whole lines. It changes in the same cycle in which vpos changes, i.e. when hpos = HMIN.
- fsync:
  - High for exactly one cycle, in the cycle where (hpos,vpos) = (HMIN,VMIN) after a wrap from (HRES-1,VRES-1).
  - Not asserted in the reset-held state or on the first cycle after reset release. The first fsync occurs one full frame (1,237,500 clocks at defaults) after the first counting edge.
  - Downstream objects update their motion state on fsync. It falls in vertical blanking, so the position update never tears the visible frame.
- No gaps or stalls: the frame period is exactly (HRES-HMIN)*(VRES-VMIN) clocks.

Test Plan:
- Reset: hold rst_n=0 and toggle the clock → hpos=-370, vpos=-30, de=0, fsync=0, hsync=vsync=0, vblank=1. Deassert → hpos=-369 after the first edge.
- Line timing: run one line and sample every cycle → hsync high exactly for hpos -260..-221 (40 clocks). hpos wraps from 1279 to -370 and vpos increments at that same edge. Line period = 1650 clocks.
- Frame timing: run 2 frames and log fsync → first fsync 1,237,500 clocks after release, then every 1,237,500 clocks, each 1 cycle wide, coincident with hpos=-370, vpos=-30.
- Active window: count de-high cycles over one frame → exactly 921,600. The first de is at (0,0), the last at (1279,719). vblank=1 exactly when vpos < 0.
- Vsync: vsync high on vpos -25..-21 only, asserting and deasserting in cycles where hpos=-370.
- Async reset mid-frame: pull rst_n low at hpos=500, vpos=300 between clock edges → outputs reach reset values before the next edge with no fsync emitted. After release, the full-frame count to the first fsync is restarted.
